dispatch_3: RTL
===============

Name: dispatch_3

Overview:
- Clocked dispatch stage directly upstream of the 3-way request merge.
- Accepts one decoded instruction per four-phase handshake and classifies its opcode into one of three paths:
  - path 1: branch/jump
  - path 2: store
  - path 3: ALU/load/NOP
- Drives the matching req_k and holds opcode_out stable for the downstream merge until that path's four-phase cycle completes.
- Acknowledges the producer only after the downstream transaction completes.

Parameters:
- SYNC_STAGES, 2, flops per synchronizer on asynchronous inputs in_req, ack_1, ack_2, ack_3 (legal values 2..3).
- CNT_W, 16, width of the completed-dispatch counter.

Ports:
- clk  input  1  single clock.
- rst_n  input  1  asynchronous active-low reset.
- in_req  input  1  producer request (four-phase, asynchronous to clk).
- in_instr  input  32  instruction word; stable while in_req is high.
- in_ack  output  1  acknowledge to producer.
- opcode_out  output  7  captured opcode; feeds the merge stage opcode input.
- instr_out  output  32  captured instruction word.
- req_1  output  1  request, branch/jump path.
- req_2  output  1  request, store path.
- req_3  output  1  request, ALU/load/NOP path.
- ack_1  input  1  acknowledge, path 1 (asynchronous).
- ack_2  input  1  acknowledge, path 2 (asynchronous).
- ack_3  input  1  acknowledge, path 3 (asynchronous).
- illegal  output  1  one-cycle pulse when an unsupported opcode is dropped.
- dispatch_cnt  output  CNT_W  count of completed dispatches.

Behaviour:
- Reset (rst_n low, asynchronous):
  - in_ack, req_1..3, illegal = 0.
  - opcode_out = 7'b0000000; instr_out = 0; dispatch_cnt = 0.
  - All synchronizer flops = 0; FSM = IDLE.
- Synchronizers: in_req and ack_1..3 each pass through SYNC_STAGES flops. The FSM uses only the synchronized versions (s_in_req, s_ack_k).
- Opcode classification, combinational on in_instr[6:0]:
  - 1100011, 1101111 -> path 1.
  - 0100011 -> path 2.
  - 0110011, 0010011, 0000011, 0000000 -> path 3.
  - Anything else, including 0110111 (U-type), is illegal. The merge stage defines no path for U-type.
- FSM states: IDLE, ISSUE, RELEASE, DONE, DROP.
- IDLE:
  - On s_in_req = 1: capture in_instr into instr_out and in_instr[6:0] into opcode_out, and latch the path select.
  - Legal opcode -> ISSUE; illegal opcode -> DROP.
- ISSUE:
  - Exactly one req_k = 1, driven from a register.
  - Wait for s_ack_k = 1 -> RELEASE.
  - Acks on non-selected paths are ignored.
- RELEASE:
  - req_k = 0.
  - Wait for s_ack_k = 0, then in_ack = 1 and increment dispatch_cnt -> DONE.
- DONE:
  - in_ack = 1 until s_in_req = 0, then in_ack = 0 -> IDLE.
- DROP:
  - illegal = 1 for exactly the entry cycle.
  - in_ack = 1 until s_in_req = 0, then in_ack = 0 -> IDLE.
  - dispatch_cnt is not incremented.
- Latency: in_req rise -> req_k rise = SYNC_STAGES + 1 cycles.
- opcode_out and instr_out change only on capture in IDLE. They are stable from before req_k rises until after in_ack falls.
- req_1..3 are one-hot or all zero at all times. A req is never re-raised before its ack has been seen low.
- dispatch_cnt wraps modulo 2^CNT_W with no saturation.
- s_in_req already high on return to IDLE is impossible: DONE and DROP wait for it to fall. A new request is accepted only after a full return-to-zero.
- Reset mid-transaction drops req_k and in_ack to 0 immediately. The producer restarts its handshake; a downstream ack still high after reset is ignored until a new ISSUE.
- A spurious ack with no outstanding request has no effect in any state.

Decomposition:
- Shared package rv_pipe_pkg holds:
  - opcode constants (R, I_op, I_ld, U, B, J, S, NOP);
  - the path-select encoding, 3-bit one-hot matching the merge stage control;
  - the FSM state enum.
- One sub-module: sync_nff (SYNC_STAGES-deep synchronizer, reset to 0), instantiated four times.

Test Plan:
- Reset with all inputs 0 -> all outputs 0, dispatch_cnt = 0, FSM IDLE.
- in_instr = 0x00A00093 (I_op), raise in_req:
  - req_3 rises SYNC_STAGES+1 cycles later; opcode_out = 0010011.
  - Ack 1 then 0 -> req_3 falls; in_ack = 1; dispatch_cnt = 1.
  - Drop in_req -> in_ack = 0.
- in_instr = 0x00112023 (S) -> only req_2 asserts. Pulse ack_1 during ISSUE -> ignored, FSM stays in ISSUE until ack_2 arrives.
- in_instr = 0x000012B7 (U) -> illegal pulses for one cycle; no req_k asserts; in_ack = 1; dispatch_cnt unchanged.
- Assert rst_n = 0 while req_1 is high for a B-type (0x00000063) -> req_1 = 0 and in_ack = 0 asynchronously. After release, a fresh J-type handshake completes normally.
- CNT_W = 4: run 17 back-to-back dispatches -> dispatch_cnt reads 1; req_k stays one-hot throughout.

Source files
------------

// File: rtl/rv_pipe_pkg.sv
// Shared RV pipeline definitions: opcode constants, the path-select encoding
// used by the 3-way merge stage, and the dispatch FSM states.
package rv_pipe_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I_OP = 7'b0010011;
  localparam logic [6:0] OP_I_LD = 7'b0000011;
  localparam logic [6:0] OP_U    = 7'b0110111;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_J    = 7'b1101111;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_NOP  = 7'b0000000;

  // One-hot, bit k-1 selects path k of the merge stage.
  typedef enum logic [2:0] {
    PATH_NONE = 3'b000,
    PATH_1    = 3'b001,
    PATH_2    = 3'b010,
    PATH_3    = 3'b100
  } path_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_RELEASE,
    ST_DONE,
    ST_DROP
  } state_t;

  // U-type has no merge path, so it falls into the illegal bucket.
  function automatic path_t classify(input logic [6:0] op);
    path_t p;
    case (op)
      OP_B, OP_J:                        p = PATH_1;
      OP_S:                              p = PATH_2;
      OP_R, OP_I_OP, OP_I_LD, OP_NOP:    p = PATH_3;
      default:                           p = PATH_NONE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/sync_nff.sv
// N-flop synchronizer for a single asynchronous level, cleared by reset.
module sync_nff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/dispatch_3.sv
// Four-phase dispatch stage: classifies one instruction per handshake and
// runs a full return-to-zero cycle on the selected merge path.
//
// state   | meaning
// IDLE    | waiting for producer request; captures instruction on s_in_req
// ISSUE   | req_k high, waiting for selected ack to rise
// RELEASE | req_k low, waiting for selected ack to fall
// DONE    | in_ack high, waiting for producer request to fall
// DROP    | illegal opcode; in_ack high, waiting for request to fall
module dispatch_3
  import rv_pipe_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_req,
  input  logic [31:0]      in_instr,
  output logic             in_ack,
  output logic [6:0]       opcode_out,
  output logic [31:0]      instr_out,
  output logic             req_1,
  output logic             req_2,
  output logic             req_3,
  input  logic             ack_1,
  input  logic             ack_2,
  input  logic             ack_3,
  output logic             illegal,
  output logic [CNT_W-1:0] dispatch_cnt
);

  logic       s_in_req;
  logic [2:0] s_ack;
  logic [2:0] req;
  logic       sel_ack;
  state_t     state;
  path_t      path_sel;
  path_t      in_path;

  sync_nff #(.STAGES(SYNC_STAGES)) u_sync_req (
    .clk(clk), .rst_n(rst_n), .d(in_req), .q(s_in_req));
  sync_nff #(.STAGES(SYNC_STAGES)) u_sync_ack1 (
    .clk(clk), .rst_n(rst_n), .d(ack_1), .q(s_ack[0]));
  sync_nff #(.STAGES(SYNC_STAGES)) u_sync_ack2 (
    .clk(clk), .rst_n(rst_n), .d(ack_2), .q(s_ack[1]));
  sync_nff #(.STAGES(SYNC_STAGES)) u_sync_ack3 (
    .clk(clk), .rst_n(rst_n), .d(ack_3), .q(s_ack[2]));

  assign in_path = classify(in_instr[6:0]);
  // Only the latched path's ack matters; acks elsewhere are ignored.
  assign sel_ack = |(s_ack & path_sel);

  assign req_1 = req[0];
  assign req_2 = req[1];
  assign req_3 = req[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      path_sel     <= PATH_NONE;
      req          <= 3'b000;
      in_ack       <= 1'b0;
      illegal      <= 1'b0;
      opcode_out   <= 7'b0000000;
      instr_out    <= 32'h0;
      dispatch_cnt <= '0;
    end else begin
      illegal <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (s_in_req) begin
            instr_out  <= in_instr;
            opcode_out <= in_instr[6:0];
            path_sel   <= in_path;
            if (in_path != PATH_NONE) begin
              req   <= in_path;
              state <= ST_ISSUE;
            end else begin
              illegal <= 1'b1;
              in_ack  <= 1'b1;
              state   <= ST_DROP;
            end
          end
        end
        ST_ISSUE: begin
          if (sel_ack) begin
            req   <= 3'b000;
            state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!sel_ack) begin
            in_ack       <= 1'b1;
            dispatch_cnt <= dispatch_cnt + CNT_W'(1);
            state        <= ST_DONE;
          end
        end
        ST_DONE, ST_DROP: begin
          if (!s_in_req) begin
            in_ack <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        default: begin
          req    <= 3'b000;
          in_ack <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
